// File: rtl/piso_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : piso_pkg
//  Description : Shared types and helpers for the piso_serializer transmitter.
//                Holds the FSM state encoding and the bit-select function that
//                maps a shift position to a word bit for either bit order.
//  Revision    : 1.0 - initial release
// ============================================================================
package piso_pkg;

  // Widest word the bit-select helper can address (6-bit position).
  localparam int MAX_N = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } piso_state_t;

  // Returns the word bit that belongs on the line when the bit counter reads
  // 'idx'. The counter runs from last down to 0, so MSB-first uses it directly
  // and LSB-first mirrors it.
  function automatic logic bit_sel(input logic [MAX_N-1:0] word,
                                   input logic [5:0]       idx,
                                   input logic [5:0]       last,
                                   input logic             msb_first);
    logic [5:0] pos;
    pos = msb_first ? idx : (last - idx);
    return word[pos];
  endfunction

endpackage
`default_nettype wire

// File: rtl/piso_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : piso_serializer
//  Description : Parallel-in / serial-out transmitter. Accepts N-bit words over
//                a valid/ready handshake and shifts them out one bit per clock,
//                with per-bit enable and start/end-of-word strobes and an
//                optional idle gap after each word.
//  Ports       : clk       - rising-edge clock
//                rst_n     - asynchronous active-low reset
//                din       - parallel word, sampled on acceptance
//                din_valid - upstream offers din
//                din_ready - a word can be accepted this cycle (combinational)
//                sout      - serial data bit (registered, 0 when idle)
//                sout_en   - sout carries a valid bit (registered)
//                sof       - first bit of a word on sout (registered)
//                eof       - last bit of a word on sout (registered)
//                busy      - FSM is in SHIFT or GAP
//  Revision    : 1.0 - initial release
// ============================================================================
module piso_serializer
  import piso_pkg::*;
#(
  parameter int N         = 8,   // word width, 2..64
  parameter int GAP       = 0,   // idle cycles after each word
  parameter bit MSB_FIRST = 1    // 1: bit N-1 first, 0: bit 0 first
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] din,
  input  logic         din_valid,
  output logic         din_ready,
  output logic         sout,
  output logic         sout_en,
  output logic         sof,
  output logic         eof,
  output logic         busy
);

  localparam int         CW  = $clog2(N);
  localparam logic [5:0] NM1 = 6'(N - 1);

  piso_state_t   state_q, state_d;
  logic [N-1:0]  shreg_q, shreg_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sout_q, sout_d;
  logic          sout_en_q, sout_en_d;
  logic          sof_q, sof_d;
  logic          eof_q, eof_d;

  logic          w_accept;
  logic          w_gap_last;
  logic [CW-1:0] w_cnt_dec;

  assign w_cnt_dec = cnt_q - CW'(1);

  // Ready is gated by rst_n so nothing is offered while reset is held, even
  // though the state register already reads IDLE.
  assign din_ready = rst_n &
                     ((state_q == IDLE) |
                      ((state_q == SHIFT) & (cnt_q == '0) & (GAP == 0)) |
                      ((state_q == piso_pkg::GAP) & w_gap_last));

  assign w_accept = din_valid & din_ready;

  // --------------------------------------------------------------------------
  // Gap counter: only exists when an inter-word gap is configured. Loaded with
  // GAP-1 on the edge that leaves SHIFT so the last gap cycle reads 0.
  // --------------------------------------------------------------------------
  if (GAP > 0) begin : g_gap
    localparam int GW = $clog2(GAP + 1);
    logic [GW-1:0] gcnt_q, gcnt_d;

    always_comb begin
      gcnt_d = gcnt_q;
      if ((state_q == SHIFT) && (state_d == piso_pkg::GAP)) begin
        gcnt_d = GW'(GAP - 1);
      end else if ((state_q == piso_pkg::GAP) && (gcnt_q != '0)) begin
        gcnt_d = gcnt_q - GW'(1);
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        gcnt_q <= '0;
      end else begin
        gcnt_q <= gcnt_d;
      end
    end

    assign w_gap_last = (gcnt_q == '0);
  end else begin : g_nogap
    assign w_gap_last = 1'b0;
  end

  // --------------------------------------------------------------------------
  // Next-state and registered-output logic. Outputs default to idle values,
  // so GAP and IDLE drive sout=0 / sout_en=0 without extra cases.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    cnt_d     = cnt_q;
    sout_d    = 1'b0;
    sout_en_d = 1'b0;
    sof_d     = 1'b0;
    eof_d     = 1'b0;

    case (state_q)
      IDLE: begin
        state_d = IDLE;
      end
      SHIFT: begin
        if (cnt_q != '0) begin
          cnt_d     = w_cnt_dec;
          sout_d    = bit_sel(64'(shreg_q), 6'(w_cnt_dec), NM1, MSB_FIRST);
          sout_en_d = 1'b1;
          eof_d     = (w_cnt_dec == '0);
        end else if (GAP > 0) begin
          state_d = piso_pkg::GAP;
        end else begin
          state_d = IDLE;
        end
      end
      piso_pkg::GAP: begin
        if (w_gap_last) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // din_ready is only high in the cycles where a new word may start, so an
    // acceptance always overrides whatever transition the case chose.
    if (w_accept) begin
      state_d   = SHIFT;
      shreg_d   = din;
      cnt_d     = CW'(N - 1);
      sout_d    = bit_sel(64'(din), NM1, NM1, MSB_FIRST);
      sout_en_d = 1'b1;
      sof_d     = 1'b1;
      eof_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      cnt_q     <= '0;
      sout_q    <= 1'b0;
      sout_en_q <= 1'b0;
      sof_q     <= 1'b0;
      eof_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      cnt_q     <= cnt_d;
      sout_q    <= sout_d;
      sout_en_q <= sout_en_d;
      sof_q     <= sof_d;
      eof_q     <= eof_d;
    end
  end

  assign sout    = sout_q;
  assign sout_en = sout_en_q;
  assign sof     = sof_q;
  assign eof     = eof_q;
  assign busy    = (state_q != IDLE);

endmodule
`default_nettype wire
